// File: rtl/audio_sdm_out.sv
// audio_sdm_out: sample FIFO feeding a first-order 1-bit sigma-delta modulator.
// Samples are signed 8-bit values queued upstream. A programmable period
// counter produces one sample tick every max(period_i,1) enabled clocks. Each
// tick moves the FIFO head into the current-sample register, or loads midscale
// and flags an underrun when the FIFO is empty. The modulator runs on every
// enabled clock and emits a pulse-density stream proportional to the sample.
module audio_sdm_out #(
   parameter int FIFO_DEPTH = 4,
   parameter int PERIOD_W   = 16
) (
   input  logic                          clk,
   input  logic                          reset_i,
   input  logic                          enable_i,
   input  logic [PERIOD_W-1:0]           period_i,
   input  logic                          sample_valid_i,
   input  logic [7:0]                    sample_data_i,
   output logic                          sample_ready_o,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
   output logic                          underrun_o,
   output logic                          audio_o
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;

   localparam logic [LVL_W-1:0] LEVEL_FULL = LVL_W'(FIFO_DEPTH);

   // FIFO storage and bookkeeping
   logic [7:0]          mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]    level_q,  level_d;

   // Sample timing
   logic [PERIOD_W-1:0] cnt_q, cnt_d;
   logic [PERIOD_W-1:0] reload_val;
   logic                tick;

   // Current sample and modulator state
   logic [7:0]          cur_q, cur_d;
   logic [7:0]          acc_q, acc_d;
   logic                audio_q, audio_d;
   logic                underrun_q, underrun_d;

   // Datapath helpers
   logic                push;
   logic                pop;
   logic                fifo_empty;
   logic [7:0]          mod_u;
   logic [8:0]          mod_sum;

   // A period of 0 behaves like 1, so the reload value never underflows.
   always_comb begin
      reload_val = '0;
      if (period_i != '0) begin
         reload_val = period_i - PERIOD_W'(1);
      end
   end

   // Period counter: free-running down-count while enabled, parked at the
   // reload value while muted so the first tick lands a full period later.
   // period_i is only looked at when reloading, so changes never disturb the
   // count already in progress.
   always_comb begin
      tick  = 1'b0;
      cnt_d = reload_val;
      if (enable_i) begin
         if (cnt_q == '0) begin
            tick  = 1'b1;
            cnt_d = reload_val;
         end else begin
            cnt_d = cnt_q - PERIOD_W'(1);
         end
      end
   end

   // Handshake and FIFO control. There is no bypass from the push port to the
   // pop side: a sample written during an empty-FIFO tick still underruns and
   // becomes the head for the following tick.
   always_comb begin
      fifo_empty     = (level_q == '0);
      sample_ready_o = reset_i || (level_q != LEVEL_FULL);
      push           = sample_valid_i && sample_ready_o && !reset_i;
      pop            = tick && !fifo_empty;
      underrun_d     = tick && fifo_empty;

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;

      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      unique case ({push, pop})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
   end

   // Current-sample register: loads the FIFO head on a tick, falls back to
   // midscale (signed zero) on an underrun, otherwise holds, including while
   // playback is muted.
   always_comb begin
      cur_d = cur_q;
      if (pop) begin
         cur_d = mem_q[rd_ptr_q];
      end else if (underrun_d) begin
         cur_d = 8'h00;
      end
   end

   // First-order modulator. Flipping the sign bit maps the signed sample onto
   // 0..255, so the carry out of the 8-bit phase accumulator fires exactly u
   // times in any 256 clocks. Only the low eight bits are kept as state; the
   // carry is what goes to the pin. Muting clears the phase so playback
   // restarts from a known pattern.
   always_comb begin
      mod_u   = {~cur_q[7], cur_q[6:0]};
      mod_sum = {1'b0, acc_q} + {1'b0, mod_u};
      acc_d   = 8'h00;
      audio_d = 1'b0;
      if (enable_i) begin
         acc_d   = mod_sum[7:0];
         audio_d = mod_sum[8];
      end
   end

   // Sample storage; contents need no reset because level gates every read.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= sample_data_i;
      end
   end

   // Control and datapath state with synchronous reset; reset discards any
   // queued samples and never raises an underrun.
   always_ff @(posedge clk) begin
      if (reset_i) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         cnt_q      <= reload_val;
         cur_q      <= 8'h00;
         acc_q      <= 8'h00;
         audio_q    <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         cnt_q      <= cnt_d;
         cur_q      <= cur_d;
         acc_q      <= acc_d;
         audio_q    <= audio_d;
         underrun_q <= underrun_d;
      end
   end

   // Registered outputs
   always_comb begin
      fifo_level_o = level_q;
      underrun_o   = underrun_q;
      audio_o      = audio_q;
   end

endmodule

// File: tb/tb_audio_sdm_out.sv
// Directed testbench for audio_sdm_out with hand-computed expectations.
// Inputs change just after a falling edge; outputs are sampled on the falling
// edge that follows each rising edge.
module tb_audio_sdm_out;

   logic        clk = 1'b0;
   logic        resetIn;
   logic        enableIn;
   logic [15:0] periodIn;
   logic        sampleValid;
   logic [7:0]  sampleData;
   logic        sampleReady;
   logic [2:0]  fifoLevel;
   logic        underrun;
   logic        audio;

   int checkCount = 0;
   int passCount  = 0;

   // Window measurement results
   int ones;
   int unders;
   int firstUnder;

   logic [7:0] pushData   [6];
   int         winOnes    [6];
   int         winLevel   [6];
   int         winUnders  [6];

   always #5 clk = ~clk;

   audio_sdm_out #(
      .FIFO_DEPTH (4),
      .PERIOD_W   (16)
   ) dut (
      .clk            (clk),
      .reset_i        (resetIn),
      .enable_i       (enableIn),
      .period_i       (periodIn),
      .sample_valid_i (sampleValid),
      .sample_data_i  (sampleData),
      .sample_ready_o (sampleReady),
      .fifo_level_o   (fifoLevel),
      .underrun_o     (underrun),
      .audio_o        (audio)
   );

   // Count one comparison and report it if it does not match.
   task automatic checkOutput(input string tag, input int observed, input int expected);
      checkCount++;
      if (observed == expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Drive one set of inputs across a single rising edge, then land on the
   // following falling edge where outputs are stable.
   task automatic applyStimulus(input logic rst, input logic en, input logic vld,
                                input logic [7:0] data);
      resetIn     = rst;
      enableIn    = en;
      sampleValid = vld;
      sampleData  = data;
      @(negedge clk);
   endtask

   // Run n enabled clocks without pushes, counting audio highs and underruns.
   task automatic runWindow(input int n, output int nOnes, output int nUnders,
                            output int firstAt);
      nOnes   = 0;
      nUnders = 0;
      firstAt = -1;
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
         if (audio) nOnes++;
         if (underrun) begin
            nUnders++;
            if (firstAt < 0) firstAt = i + 1;
         end
      end
   endtask

   initial begin
      resetIn     = 1'b1;
      enableIn    = 1'b0;
      periodIn    = 16'd256;
      sampleValid = 1'b0;
      sampleData  = 8'h00;

      // Idle playback: midscale output and an underrun every 256 clocks.
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
      checkOutput("rst_ready",    sampleReady, 1);
      checkOutput("rst_level",    fifoLevel,   0);
      checkOutput("rst_audio",    audio,       0);
      checkOutput("rst_underrun", underrun,    0);
      runWindow(256, ones, unders, firstUnder);
      checkOutput("idle_w0_ones",   ones,       128);
      checkOutput("idle_w0_unders", unders,     1);
      checkOutput("idle_w0_first",  firstUnder, 256);
      runWindow(256, ones, unders, firstUnder);
      checkOutput("idle_w1_ones",   ones,       128);
      checkOutput("idle_w1_first",  firstUnder, 256);

      // Fill while muted, overflow by two, then play back in order.
      pushData  = '{8'h40, 8'h80, 8'h7F, 8'hC0, 8'h55, 8'h66};
      winOnes   = '{128, 192, 0, 255, 64, 128};
      winLevel  = '{3, 2, 1, 0, 0, 0};
      winUnders = '{0, 0, 0, 0, 1, 1};
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b1, pushData[i]);
         checkOutput($sformatf("fill_ready_%0d", i), sampleReady, (i < 3) ? 1 : 0);
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
      checkOutput("fill_level", fifoLevel, 4);
      checkOutput("muted_audio", audio, 0);
      checkOutput("muted_underrun", underrun, 0);
      for (int w = 0; w < 6; w++) begin
         runWindow(256, ones, unders, firstUnder);
         checkOutput($sformatf("play_w%0d_ones", w),   ones,      winOnes[w]);
         checkOutput($sformatf("play_w%0d_level", w),  fifoLevel, winLevel[w]);
         checkOutput($sformatf("play_w%0d_unders", w), unders,    winUnders[w]);
      end

      // Period 0 ticks every clock; a push into an empty FIFO on a tick
      // still underruns and is popped on the next tick.
      periodIn = 16'd0;
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
      checkOutput("p0_e1_underrun", underrun, 1);
      checkOutput("p0_e1_audio",    audio,    0);
      applyStimulus(1'b0, 1'b1, 1'b1, 8'h80);
      checkOutput("p0_e2_underrun", underrun,  1);
      checkOutput("p0_e2_level",    fifoLevel, 1);
      checkOutput("p0_e2_audio",    audio,     1);
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
      checkOutput("p0_e3_underrun", underrun,  0);
      checkOutput("p0_e3_level",    fifoLevel, 0);
      checkOutput("p0_e3_audio",    audio,     0);
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
      checkOutput("p0_e4_underrun", underrun, 1);
      checkOutput("p0_e4_audio",    audio,    0);
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
      checkOutput("p0_e5_audio",    audio,    1);

      // Reset mid-period with three queued samples discards them all.
      periodIn = 16'd8;
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b1, 8'h7F);
      end
      checkOutput("mid_level", fifoLevel, 3);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
      end
      applyStimulus(1'b1, 1'b1, 1'b1, 8'h33);
      checkOutput("mid_rst_level",    fifoLevel,   0);
      checkOutput("mid_rst_audio",    audio,       0);
      checkOutput("mid_rst_underrun", underrun,    0);
      checkOutput("mid_rst_ready",    sampleReady, 1);
      runWindow(8, ones, unders, firstUnder);
      checkOutput("mid_post_ones",   ones,       4);
      checkOutput("mid_post_unders", unders,     1);
      checkOutput("mid_post_first",  firstUnder, 8);

      // Mute keeps cur but clears the modulator; unmute restarts from zero
      // phase and the counter restarts a full period.
      periodIn = 16'd4;
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h40);
      runWindow(4, ones, unders, firstUnder);
      checkOutput("mute_pop_unders", unders,    0);
      checkOutput("mute_pop_level",  fifoLevel, 0);
      runWindow(2, ones, unders, firstUnder);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
      checkOutput("mute_audio_0", audio, 0);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
      checkOutput("mute_audio_1", audio, 0);
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
      checkOutput("unmute_e1_audio", audio, 0);
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
      checkOutput("unmute_e2_audio", audio, 1);
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
      checkOutput("unmute_e3_audio",    audio,    1);
      checkOutput("unmute_e3_underrun", underrun, 0);
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
      checkOutput("unmute_e4_underrun", underrun, 1);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
